ai_status_monitor: RTL

AI_STATUS_MONITOR -- requirements
Module: AI_status_monitor

---
 rtl/ai_status_monitor.sv | 81 ++++++++
 1 files changed

// File: rtl/ai_status_monitor.sv
// rtl/ai_status_monitor.sv - per-channel sticky error flags, saturating counters, first-error capture and irq
module ai_status_monitor #(
   parameter int NCH   = 4,
   parameter int CNT_W = 8,
   parameter int EDGE  = 0,
   localparam int IDW  = (NCH > 1) ? $clog2(NCH) : 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 init,
   input  logic [NCH-1:0]       err_in,
   input  logic [NCH-1:0]       clr,
   input  logic [NCH-1:0]       irq_mask,
   output logic [NCH-1:0]       sticky,
   output logic [NCH*CNT_W-1:0] cnt,
   output logic                 first_vld,
   output logic [IDW-1:0]       first_id,
   output logic                 irq
);

   logic [NCH-1:0]   prev;
   logic [NCH-1:0]   evt;
   logic [IDW-1:0]   low_id;
   logic [CNT_W-1:0] cnt_r [NCH];

   always_comb begin
      evt = (EDGE != 0) ? (err_in & ~prev) : err_in;
   end

   // Scan downward so the lowest flagged channel wins.
   always_comb begin
      low_id = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (evt[i]) low_id = IDW'(i);
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_cnt
      assign cnt[g*CNT_W +: CNT_W] = cnt_r[g];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         prev      <= '0;
         sticky    <= '0;
         first_vld <= 1'b0;
         first_id  <= '0;
         irq       <= 1'b0;
         for (int i = 0; i < NCH; i++) cnt_r[i] <= '0;
      end else begin
         // prev tracks the raw input regardless of init/clr so edge detect stays coherent.
         prev <= err_in;
         if (init) begin
            sticky    <= '0;
            first_vld <= 1'b0;
            first_id  <= '0;
            irq       <= 1'b0;
            for (int i = 0; i < NCH; i++) cnt_r[i] <= '0;
         end else begin
            for (int i = 0; i < NCH; i++) begin
               if (evt[i]) begin
                  sticky[i] <= 1'b1;
                  if (clr[i])
                     cnt_r[i] <= CNT_W'(1);
                  else if (cnt_r[i] != {CNT_W{1'b1}})
                     cnt_r[i] <= cnt_r[i] + CNT_W'(1);
               end else if (clr[i]) begin
                  sticky[i] <= 1'b0;
                  cnt_r[i]  <= '0;
               end
            end
            if (!first_vld && (|evt)) begin
               first_vld <= 1'b1;
               first_id  <= low_id;
            end
            irq <= |(sticky & ~irq_mask);
         end
      end
   end

endmodule
